wb_cfg_loader: RTL and testbench

- Wishbone classic slave inside user_project, directly downstream of the wrapper's management-SoC Wishbone port.
- Accepts 32-bit configuration words from firmware, buffers them in a small FIFO, and serialises them LSB-first onto the FPGA tile configuration shift chain.
- Issues a latch pulse on command once the chain is fully shifted.
- Raises an interrupt when the latch completes.

---
 rtl/wb_cfg_loader_pkg.sv | 26 ++
 rtl/wb_cfg_loader_if.sv | 24 ++
 rtl/wb_cfg_loader_fifo.sv | 53 +++++
 rtl/wb_cfg_loader.sv | 165 ++++++++++++++++
 tb/tb_wb_cfg_loader.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/wb_cfg_loader_pkg.sv
// Shared register map, control/status bit positions and loader FSM states.
// Imported by the loader top and its testbench.
package cfg_loader_pkg;

  localparam logic [7:0] REG_CTRL   = 8'h00;
  localparam logic [7:0] REG_STATUS = 8'h04;
  localparam logic [7:0] REG_DATA   = 8'h08;
  localparam logic [7:0] REG_COUNT  = 8'h0C;

  localparam int CTRL_IRQ_EN    = 0;
  localparam int CTRL_LATCH_REQ = 1;
  localparam int CTRL_FLUSH     = 2;

  localparam int ST_BUSY  = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_DONE  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_e;

endpackage

// File: rtl/wb_cfg_loader_if.sv
// Wishbone classic slave bundle between the management SoC and the config loader.
// The master drives cyc/stb/we/sel/adr/dat_i and holds them until it sees ack.
interface wb_cfg_loader_if;

  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

endinterface

// File: rtl/wb_cfg_loader_fifo.sv
// Synchronous word FIFO, show-ahead read (dout valid while !empty), zero-cycle latency.
// A push when full is accepted only if a pop happens in the same cycle; flush empties it.
module cfg_word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW:0]      cnt_q;
  logic             do_pop;
  logic             do_push;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/wb_cfg_loader.sv
// Wishbone config loader: FIFO-buffered words shifted LSB-first onto the tile chain, then latched.
// First cfg_shift 2 cycles after the DATA ack; a DATA write while full is dropped (OVF), never stalled.
module wb_cfg_loader
  import cfg_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  wb_cfg_loader_if.slave wb,
  output logic           cfg_sdo,
  output logic           cfg_shift,
  output logic           cfg_latch,
  output logic           irq_o
);

  state_e      state_q;
  logic        ack_q;
  logic        irq_en_q, irq_en_d;
  logic        latch_req_q, latch_req_d;
  logic        ovf_q, ovf_d;
  logic        done_q, done_d;
  logic        shift_q, latch_q, irq_q;
  logic [31:0] shifter_q;
  logic [4:0]  bit_cnt_q;
  logic [31:0] count_q;
  logic [31:0] rd_dat;

  logic        req, wr_en, wr_ctrl, wr_status, wr_data;
  logic [7:0]  off;
  logic        fifo_pop, fifo_flush, fifo_full, fifo_empty, fifo_avail;
  logic [31:0] fifo_dout;
  logic        sel_unused;

  assign off        = wb.wbs_adr_i[7:0];
  assign req        = wb.wbs_cyc_i & wb.wbs_stb_i & (wb.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign wr_en      = ack_q & req & wb.wbs_we_i;
  assign wr_ctrl    = wr_en & (off == REG_CTRL);
  assign wr_status  = wr_en & (off == REG_STATUS);
  assign wr_data    = wr_en & (off == REG_DATA);
  assign fifo_flush = wr_ctrl & wb.wbs_dat_i[CTRL_FLUSH];
  assign sel_unused = ^wb.wbs_sel_i;

  // A word being flushed this cycle must not be loaded into the shifter.
  assign fifo_avail = ~fifo_empty & ~fifo_flush;
  assign fifo_pop   = fifo_avail & ((state_q == IDLE) ||
                                    ((state_q == SHIFT) && (bit_cnt_q == 5'd31)));

  cfg_word_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (wr_data),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   (wb.wbs_dat_i),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    irq_en_d    = irq_en_q;
    latch_req_d = latch_req_q;
    ovf_d       = ovf_q;
    done_d      = done_q;
    if (wr_status && wb.wbs_dat_i[ST_DONE]) done_d = 1'b0;
    if (state_q == LATCH) begin
      done_d      = 1'b1;
      latch_req_d = 1'b0;
    end
    if (wr_ctrl) begin
      irq_en_d = wb.wbs_dat_i[CTRL_IRQ_EN];
      if (wb.wbs_dat_i[CTRL_LATCH_REQ]) latch_req_d = 1'b1;
      if (wb.wbs_dat_i[CTRL_FLUSH])     ovf_d       = 1'b0;
    end
    if (wr_data && fifo_full && !fifo_pop) ovf_d = 1'b1;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      ack_q       <= 1'b0;
      irq_en_q    <= 1'b0;
      latch_req_q <= 1'b0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
      shift_q     <= 1'b0;
      latch_q     <= 1'b0;
      irq_q       <= 1'b0;
      shifter_q   <= '0;
      bit_cnt_q   <= '0;
      count_q     <= '0;
    end else begin
      ack_q       <= req & ~ack_q;
      irq_en_q    <= irq_en_d;
      latch_req_q <= latch_req_d;
      ovf_q       <= ovf_d;
      done_q      <= done_d;
      irq_q       <= irq_en_d & done_d;
      latch_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fifo_avail) begin
            shifter_q <= fifo_dout;
            bit_cnt_q <= '0;
            shift_q   <= 1'b1;
            state_q   <= SHIFT;
          end else if (latch_req_q) begin
            latch_q <= 1'b1;
            state_q <= LATCH;
          end
        end
        SHIFT: begin
          shifter_q <= shifter_q >> 1;
          bit_cnt_q <= bit_cnt_q + 5'd1;
          if (count_q != '1) count_q <= count_q + 32'd1;
          if (bit_cnt_q == 5'd31) begin
            // Reload on the last bit so streaming words leave no gap on the chain.
            if (fifo_avail) begin
              shifter_q <= fifo_dout;
            end else begin
              shift_q <= 1'b0;
              if (latch_req_q) begin
                latch_q <= 1'b1;
                state_q <= LATCH;
              end else begin
                state_q <= IDLE;
              end
            end
          end
        end
        LATCH: begin
          count_q <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    rd_dat = '0;
    if (ack_q && !wb.wbs_we_i) begin
      case (off)
        REG_CTRL:   rd_dat = {31'd0, irq_en_q};
        REG_STATUS: rd_dat = {27'd0, done_q, ovf_q, fifo_empty, fifo_full,
                              (state_q != IDLE) | ~fifo_empty};
        REG_COUNT:  rd_dat = count_q;
        default:    rd_dat = '0;
      endcase
    end
  end

  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = rd_dat;
  assign cfg_sdo      = shifter_q[0];
  assign cfg_shift    = shift_q;
  assign cfg_latch    = latch_q;
  assign irq_o        = irq_q;

endmodule

// File: tb/tb_wb_cfg_loader.sv
// Directed-sequence bench with random payloads; expected chain traffic comes from a word-queue model.
module tb_wb_cfg_loader;
  import cfg_loader_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h3000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_cfg_loader_if bus ();
  logic cfg_sdo, cfg_shift, cfg_latch, irq_o;

  wb_cfg_loader #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wb        (bus),
    .cfg_sdo   (cfg_sdo),
    .cfg_shift (cfg_shift),
    .cfg_latch (cfg_latch),
    .irq_o     (irq_o)
  );

  int          checks = 0;
  int          errors = 0;
  int unsigned cycle  = 0;
  int unsigned last_ack;
  bit          sb[$];
  int unsigned sc[$];
  int unsigned lc[$];
  int unsigned ic[$];
  logic        irq_prev = 1'b0;

  bit          exp_bits[$];
  int unsigned model_count = 0;
  logic [31:0] words[6];
  logic [31:0] rdat;
  bit          acked;

  always @(posedge clk) cycle <= cycle + 1;

  always @(negedge clk) begin
    if (cfg_shift) begin
      sb.push_back(cfg_sdo);
      sc.push_back(cycle);
    end
    if (cfg_latch) lc.push_back(cycle);
    if (irq_o && !irq_prev) ic.push_back(cycle);
    irq_prev = irq_o;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                      output logic [31:0] rd, output bit ok);
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
    bus.wbs_adr_i = adr;  bus.wbs_dat_i = wdat; bus.wbs_sel_i = 4'hF;
    ok = 1'b0;
    rd = '0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.wbs_ack_o === 1'b1) begin
        ok = 1'b1;
        rd = bus.wbs_dat_o;
        last_ack = cycle;
        break;
      end
    end
    if (ok) begin
      @(posedge clk); #1;
    end
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
  endtask

  task automatic wr(input string tag, input logic [7:0] off, input logic [31:0] d);
    logic [31:0] unused_rd;
    bit ok;
    xfer(BASE | 32'(off), 1'b1, d, unused_rd, ok);
    chk({tag, "_ack"}, 32'(ok), 32'd1);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] off, input logic [31:0] exp);
    logic [31:0] d;
    bit ok;
    xfer(BASE | 32'(off), 1'b0, 32'd0, d, ok);
    chk({tag, "_ack"}, 32'(ok), 32'd1);
    chk(tag, d, exp);
  endtask

  task automatic add_word(input logic [31:0] w);
    for (int b = 0; b < 32; b++) exp_bits.push_back(w[b]);
    model_count += 32;
  endtask

  task automatic reset_logs();
    @(posedge clk); #1;
    sb.delete(); sc.delete(); lc.delete(); ic.delete(); exp_bits.delete();
  endtask

  task automatic wait_quiet(input string tag);
    int quiet = 0;
    bit ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (cfg_shift || cfg_latch) quiet = 0;
      else quiet++;
      if (quiet >= 4) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_timeout"}, 32'(ok), 32'd1);
  endtask

  task automatic cmp_stream(input string tag);
    int mism = 0;
    int n = (sb.size() < exp_bits.size()) ? sb.size() : exp_bits.size();
    chk({tag, "_len"}, 32'(sb.size()), 32'(exp_bits.size()));
    for (int i = 0; i < n; i++) if (sb[i] !== exp_bits[i]) mism++;
    chk({tag, "_bits"}, 32'(mism), 32'd0);
    if (sb.size() > 0) chk({tag, "_gapless"}, sc[sc.size()-1] - sc[0] + 1, 32'(sb.size()));
  endtask

  initial begin
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = 4'h0; bus.wbs_adr_i = '0;   bus.wbs_dat_i = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_shift", 32'(cfg_shift), 32'd0);
    chk("rst_sdo",   32'(cfg_sdo),   32'd0);
    chk("rst_latch", 32'(cfg_latch), 32'd0);
    chk("rst_irq",   32'(irq_o),     32'd0);
    chk("rst_dat_o", bus.wbs_dat_o,  32'd0);
    rd_chk("rst_status", REG_STATUS, 32'h4);
    rd_chk("rst_count",  REG_COUNT,  32'd0);

    // Single word 0xA5: latency, bit order, count
    reset_logs();
    add_word(32'h0000_00A5);
    wr("a5_data", REG_DATA, 32'h0000_00A5);
    wait_quiet("a5");
    chk("a5_first_shift", (sc.size() > 0) ? sc[0] : 32'd0, last_ack + 2);
    cmp_stream("a5");
    rd_chk("a5_count", REG_COUNT, model_count);
    rd_chk("data_reads_zero", REG_DATA, 32'd0);

    // Burst while the shifter is busy: it plus DEPTH queued words are accepted, the rest dropped
    reset_logs();
    for (int i = 0; i < 6; i++) words[i] = $urandom;
    for (int i = 0; i < 6; i++) begin
      if (i < 1 + DEPTH) add_word(words[i]);
      wr("ovf_data", REG_DATA, words[i]);
    end
    wait_quiet("ovf");
    cmp_stream("ovf");
    rd_chk("ovf_status", REG_STATUS, 32'h0C);
    rd_chk("ovf_count", REG_COUNT, model_count);

    // Flush while shifting: current word completes, queued words discarded, OVF cleared
    reset_logs();
    for (int i = 0; i < 3; i++) words[i] = $urandom;
    add_word(words[0]);
    for (int i = 0; i < 3; i++) wr("fl_data", REG_DATA, words[i]);
    wr("fl_ctrl", REG_CTRL, 32'h4);
    wait_quiet("fl");
    cmp_stream("fl");
    rd_chk("fl_status", REG_STATUS, 32'h4);
    rd_chk("fl_count", REG_COUNT, model_count);
    rd_chk("fl_ctrl_rd", REG_CTRL, 32'd0);

    // Latch request while two words are queued
    reset_logs();
    for (int i = 0; i < 2; i++) begin
      words[i] = $urandom;
      add_word(words[i]);
      wr("lt_data", REG_DATA, words[i]);
    end
    wr("lt_ctrl", REG_CTRL, 32'h3);
    wait_quiet("lt");
    model_count = 0;
    cmp_stream("lt");
    chk("lt_pulses", 32'(lc.size()), 32'd1);
    chk("lt_cycle", (lc.size() > 0) ? lc[0] : 32'd0, ((sc.size() > 0) ? sc[sc.size()-1] : 32'd0) + 1);
    chk("lt_irq_rise", (ic.size() > 0) ? ic[0] : 32'd0, ((lc.size() > 0) ? lc[0] : 32'd0) + 1);
    chk("lt_irq_level", 32'(irq_o), 32'd1);
    rd_chk("lt_status", REG_STATUS, 32'h14);
    rd_chk("lt_count", REG_COUNT, model_count);
    rd_chk("lt_ctrl_rd", REG_CTRL, 32'd1);
    wr("lt_w1c", REG_STATUS, 32'h10);
    chk("lt_irq_clr", 32'(irq_o), 32'd0);
    rd_chk("lt_status_clr", REG_STATUS, 32'h4);

    // Asynchronous reset in the middle of a word
    reset_logs();
    wr("rs_data", REG_DATA, $urandom);
    acked = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sb.size() >= 11) begin
        acked = 1'b1;
        break;
      end
    end
    chk("rs_reach_bit10", 32'(acked), 32'd1);
    rst = 1'b1;
    #1;
    chk("rs_shift_drop", 32'(cfg_shift), 32'd0);
    chk("rs_irq", 32'(irq_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rd_chk("rs_status", REG_STATUS, 32'h4);
    rd_chk("rs_count", REG_COUNT, 32'd0);

    // Address decode
    xfer(32'h3000_0100, 1'b0, 32'd0, rdat, acked);
    chk("miss_no_ack", 32'(acked), 32'd0);
    rd_chk("unmapped_1c", 8'h1C, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
